dma_xfer_engine: RTL and testbench

Single-channel memory-to-memory DMA transfer engine: the DUT-side stage fed by the DMA descriptor interface. It accepts one descriptor (source, destination, word count) over a valid/ready handshake, issues in-order single-word reads, buffers returned data in a small FIFO, and issues single-word writes to the destination. Completion is reported with a one-cycle `done` pulse and an error flag.

---
 rtl/dma_xfer_engine_if.sv | 55 +++++
 rtl/dma_xfer_engine.sv | 135 +++++++++++++
 tb/tb_dma_xfer_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_xfer_engine_if.sv
// Descriptor, read-request/response and write buses of the DMA transfer engine.
// The engine side uses the master modport; the memory/host side uses slave.
// DMA_XFER_ENGINE_ABORT_EN adds the abort input.
interface dma_xfer_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_WIDTH-1:0] desc_src;
  logic [ADDR_WIDTH-1:0] desc_dst;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rsp_valid;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  err;
`ifdef DMA_XFER_ENGINE_ABORT_EN
  logic                  abort;
`endif

  modport master (
`ifdef DMA_XFER_ENGINE_ABORT_EN
    input  abort,
`endif
    input  desc_valid, desc_src, desc_dst, desc_len,
    output desc_ready,
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output busy, done, err
  );

  modport slave (
`ifdef DMA_XFER_ENGINE_ABORT_EN
    output abort,
`endif
    output desc_valid, desc_src, desc_dst, desc_len,
    input  desc_ready,
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  busy, done, err
  );
endinterface

// File: rtl/dma_xfer_engine.sv
// Single-channel memory-to-memory DMA engine. One descriptor at a time:
// in-order single-word reads into a small FIFO, single-word writes out of it.
// Reads are credited so outstanding + buffered never exceeds FIFO_DEPTH,
// which is why responses never need back-pressure.
// Optional: DMA_XFER_ENGINE_ABORT_EN adds a sticky abort path.
module dma_xfer_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  dma_xfer_engine_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state, state_nxt;
  logic                  up_q;
  logic                  err_q, err_nxt;
  logic                  ab_q;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr_q;
  logic [LEN_WIDTH-1:0]  rd_left, wr_left;
  logic [CW-1:0]         outst, out_nxt, cnt;
  logic [PW-1:0]         wp, rp;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  accept, rd_fire, rsp_acc, push, wr_fire;

  assign bus.desc_ready   = (state == IDLE) && up_q;
  assign accept           = bus.desc_ready && bus.desc_valid;
  assign bus.rd_req_valid = (state == RUN) && !ab_q && (rd_left != '0) &&
                            ((outst + cnt) < CW'(FIFO_DEPTH));
  assign bus.rd_req_addr  = rd_addr;
  assign rd_fire          = bus.rd_req_valid && bus.rd_req_ready;
  // Stray responses (nothing outstanding) are dropped; during abort they are
  // still counted off but not buffered.
  assign rsp_acc          = (state == RUN) && bus.rd_rsp_valid && (outst != '0);
  assign push             = rsp_acc && !ab_q;
  assign bus.wr_valid     = (state == RUN) && !ab_q && (cnt != '0);
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = bus.wr_valid ? mem[rp] : '0;
  assign wr_fire          = bus.wr_valid && bus.wr_ready;
  assign out_nxt          = outst + CW'(rd_fire) - CW'(rsp_acc);
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == FIN);
  assign bus.err          = (state == FIN) && err_q;

`ifdef DMA_XFER_ENGINE_ABORT_EN
  // Sticky abort: armed by abort in RUN, cleared on the way out through FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ab_q <= 1'b0;
    else if (state == FIN)              ab_q <= 1'b0;
    else if (state == RUN && bus.abort) ab_q <= 1'b1;
  end
`else
  assign ab_q = 1'b0;
`endif

  // Next state and completion status.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      IDLE: if (accept) begin
        err_nxt   = (bus.desc_len == '0);
        state_nxt = (bus.desc_len == '0) ? FIN : RUN;
      end
      RUN: begin
        if (wr_fire && wr_left == LEN_WIDTH'(1)) begin
          state_nxt = FIN;
          err_nxt   = 1'b0;
        end else if (ab_q && out_nxt == '0) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, address/length counters and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      up_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_addr   <= '0;
      wr_addr_q <= '0;
      rd_left   <= '0;
      wr_left   <= '0;
      outst     <= '0;
      cnt       <= '0;
      wp        <= '0;
      rp        <= '0;
    end else begin
      up_q  <= 1'b1;
      state <= state_nxt;
      err_q <= err_nxt;
      outst <= out_nxt;
      if (accept) begin
        rd_addr   <= bus.desc_src;
        wr_addr_q <= bus.desc_dst;
        rd_left   <= bus.desc_len;
        wr_left   <= bus.desc_len;
      end
      if (rd_fire) begin
        rd_addr <= rd_addr + STEP;
        rd_left <= rd_left - LEN_WIDTH'(1);
      end
      if (wr_fire) begin
        wr_addr_q <= wr_addr_q + STEP;
        wr_left   <= wr_left - LEN_WIDTH'(1);
        rp        <= rp + PW'(1);
      end
      if (push) wp <= wp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(wr_fire);
      // Abort discards whatever is buffered.
      if (ab_q) begin
        cnt <= '0;
        wp  <= '0;
        rp  <= '0;
      end
    end
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.rd_rsp_data;
  end
endmodule

// File: tb/tb_dma_xfer_engine.sv
// Self-checking bench for dma_xfer_engine: a behavioural memory (data is a
// hash of the address) returns in-order responses with configurable latency,
// and the expected read/write streams are derived from each descriptor.
module tb_dma_xfer_engine;
  localparam int AW = 32, DW = 32, LW = 16, FD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dma_xfer_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
  dma_xfer_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int t; logic [31:0] d; } pend_t;

  int checks = 0, errors = 0;
  int cyc = 0, nreads = 0, nwrites = 0, nrsp = 0, vld_seen = 0;
  int last_wr_edge = 0, last_rsp_edge = 0;
  int lat_min = 1, lat_max = 1;
  bit rd_rand = 0, wr_rand = 0, rsp_rand = 0, wr_stall = 0, spurious = 0;
  logic [31:0] salt;
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$], rd_log[$];
  pend_t pend[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory / sink side: decide handshakes for the coming edge at each negedge.
  initial begin
    logic [31:0] a;
    bus.rd_req_ready = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_data = '0; bus.wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
        bus.rd_req_ready = 1'b0; bus.wr_ready = 1'b0; bus.rd_rsp_valid = 1'b0;
        continue;
      end
      if (bus.rd_req_valid || bus.wr_valid) vld_seen++;
      bus.rd_rsp_valid = 1'b0;
      bus.rd_rsp_data  = '0;
      if (pend.size() != 0) begin
        if (pend[0].t <= cyc && (!rsp_rand || $urandom_range(0, 1) == 1)) begin
          bus.rd_rsp_valid = 1'b1;
          bus.rd_rsp_data  = pend[0].d;
          void'(pend.pop_front());
          nrsp++;
          last_rsp_edge = cyc;
        end
      end else if (spurious && $urandom_range(0, 2) == 0) begin
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_data  = $urandom;
      end
      bus.rd_req_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'(exp_rd.size()), 64'd1);
        else begin
          a = exp_rd.pop_front();
          chk("rd_addr", bus.rd_req_addr, a);
        end
        rd_log.push_back(bus.rd_req_addr);
        pend.push_back('{cyc + lat_min + int'($urandom_range(0, lat_max - lat_min)),
                         mdata(bus.rd_req_addr)});
        nreads++;
      end
      bus.wr_ready = wr_stall ? 1'b0 : (wr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (bus.wr_valid && bus.wr_ready) begin
        if (exp_wa.size() == 0) chk("wr_unexpected", 64'(exp_wa.size()), 64'd1);
        else begin
          a = exp_wa.pop_front();
          chk("wr_addr", bus.wr_addr, a);
          a = exp_wd.pop_front();
          chk("wr_data", bus.wr_data, a);
        end
        nwrites++;
        last_wr_edge = cyc;
      end
    end
  end

  // Offer a descriptor; t returns the edge at which it is accepted.
  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                      output int t);
    int n = 0;
    for (int i = 0; i < int'(l); i++) begin
      exp_rd.push_back(s + 32'(4 * i));
      exp_wa.push_back(d + 32'(4 * i));
      exp_wd.push_back(mdata(s + 32'(4 * i)));
    end
    bus.desc_src = s; bus.desc_dst = d; bus.desc_len = l; bus.desc_valid = 1'b1;
    while (!bus.desc_ready && n < 200) begin @(negedge clk); #2; n++; end
    chk("desc_ready", bus.desc_ready, 1);
    t = cyc;
    @(negedge clk); #2;
    bus.desc_valid = 1'b0;
    if (l == 0) begin
      chk("zero_done", bus.done, 1);
      chk("zero_err", bus.err, 1);
    end else begin
      chk("rd_first", bus.rd_req_valid, 1);
      chk("no_early_done", bus.done, 0);
    end
  endtask

  task automatic wait_done(input bit exp_err, output int dcyc);
    int n = 0;
    while (!bus.done && n < 600) begin @(negedge clk); #2; n++; end
    chk("done_seen", bus.done, 1);
    dcyc = cyc;
    chk("err", bus.err, exp_err);
    chk("busy_fin", bus.busy, 1);
    @(negedge clk); #2;
    chk("done_pulse", bus.done, 0);
    chk("ready_again", bus.desc_ready, 1);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic post_chk(input int len, input int w0, input int dcyc);
    chk("rd_remaining", 64'(exp_rd.size()), 0);
    chk("wr_remaining", 64'(exp_wa.size()), 0);
    chk("nwrites", 64'(nwrites - w0), 64'(len));
    chk("done_latency", 64'(dcyc), 64'(last_wr_edge + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int t, dcyc, w0, r0, v0, n;
    logic [31:0] s, d;
    logic [15:0] l;
    salt = $urandom;
    bus.desc_valid = 1'b0; bus.desc_src = '0; bus.desc_dst = '0; bus.desc_len = '0;
`ifdef DMA_XFER_ENGINE_ABORT_EN
    bus.abort = 1'b0;
`endif
    // Reset values.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_flags", {bus.desc_ready, bus.rd_req_valid, bus.wr_valid, bus.busy, bus.done, bus.err}, 0);
    chk("rst_bus", bus.rd_req_addr | bus.wr_addr | bus.wr_data, 0);
    repeat (2) @(negedge clk); #2;
    rst_n = 1'b1;
    #1 chk("ready_pre_edge", bus.desc_ready, 0);
    @(negedge clk); #2;
    chk("ready_post_edge", bus.desc_ready, 1);

    // Basic 4-word move, next-edge memory, full throughput.
    rd_log.delete(); w0 = nwrites;
    send(32'h1000, 32'h2000, 16'd4, t);
    wait_done(1'b0, dcyc);
    post_chk(4, w0, dcyc);
    chk("basic_done_cycle", 64'(dcyc), 64'(t + 7));
    chk("basic_rd0", rd_log[0], 32'h1000);
    chk("basic_rd3", rd_log[3], 32'h100C);

    // Zero length, with stray responses on the bus.
    spurious = 1; v0 = vld_seen; r0 = nreads;
    send(32'h1234, 32'h5678, 16'd0, t);
    wait_done(1'b1, dcyc);
    repeat (4) begin @(negedge clk); #2; end
    chk("zero_done_cycle", 64'(dcyc), 64'(t + 1));
    chk("zero_no_valid", 64'(vld_seen), 64'(v0));
    chk("zero_no_reads", 64'(nreads), 64'(r0));
    spurious = 0;

    // Write stall: reads stop at the FIFO credit limit; descriptors ignored while busy.
    wr_stall = 1; w0 = nwrites; r0 = nreads;
    send(32'h3000, 32'h4000, 16'd10, t);
    repeat (20) begin
      @(negedge clk); #2;
      bus.desc_valid = 1'b1; bus.desc_src = $urandom; bus.desc_dst = $urandom; bus.desc_len = 16'($urandom);
    end
    bus.desc_valid = 1'b0;
    chk("stall_reads", 64'(nreads - r0), 64'(FD));
    chk("stall_writes", 64'(nwrites - w0), 0);
    chk("stall_rd_valid", bus.rd_req_valid, 0);
    wr_stall = 0;
    wait_done(1'b0, dcyc);
    post_chk(10, w0, dcyc);

    // Address wrap.
    rd_log.delete(); w0 = nwrites;
    send(32'hFFFF_FFF8, 32'h5000, 16'd4, t);
    wait_done(1'b0, dcyc);
    post_chk(4, w0, dcyc);
    chk("wrap_rd0", rd_log[0], 32'hFFFF_FFF8);
    chk("wrap_rd2", rd_log[2], 32'h0);
    chk("wrap_rd3", rd_log[3], 32'h4);

    // Reset after 3 of 8 writes, then a fresh descriptor.
    w0 = nwrites; n = 0;
    send(32'h6000, 32'h7000, 16'd8, t);
    while (nwrites - w0 < 3 && n < 200) begin @(negedge clk); #2; n++; end
    wr_stall = 1;
    chk("reset_prefix", 64'(nwrites - w0), 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {bus.desc_ready, bus.rd_req_valid, bus.wr_valid, bus.busy, bus.done, bus.err}, 0);
    chk("mid_rst_bus", bus.rd_req_addr | bus.wr_addr | bus.wr_data, 0);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    wr_stall = 0;
    @(negedge clk); #2;
    chk("mid_rst_no_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("ready_after_rst", bus.desc_ready, 1);
    w0 = nwrites;
    send(32'h8000, 32'h9000, 16'd2, t);
    wait_done(1'b0, dcyc);
    post_chk(2, w0, dcyc);

    // Randomized descriptors with random readiness, latency and stray responses.
    lat_min = 1; lat_max = 3; rd_rand = 1; wr_rand = 1; rsp_rand = 1; spurious = 1;
    for (int k = 0; k < 6; k++) begin
      s = $urandom; d = $urandom;
      l = (k == 0) ? 16'd1 : 16'($urandom_range(2, 24));
      w0 = nwrites;
      send(s, d, l, t);
      wait_done(1'b0, dcyc);
      post_chk(int'(l), w0, dcyc);
    end
    lat_min = 1; lat_max = 1; rd_rand = 0; wr_rand = 0; rsp_rand = 0; spurious = 0;

`ifdef DMA_XFER_ENGINE_ABORT_EN
    // Abort after 5 writes with 2 reads outstanding.
    lat_min = 2; lat_max = 2; w0 = nwrites; n = 0;
    send(32'hA000, 32'hB000, 16'd16, t);
    while (!((nwrites - w0) >= 5 && (nreads - nrsp) == 2) && n < 200) begin
      @(negedge clk); #2; n++;
    end
    chk("abort_setup", 64'(nreads - nrsp), 2);
    bus.abort = 1'b1;
    r0 = nreads; v0 = nwrites;
    @(negedge clk); #2;
    bus.abort = 1'b0;
    wait_done(1'b1, dcyc);
    chk("abort_no_reads", 64'(nreads), 64'(r0));
    chk("abort_no_writes", 64'(nwrites), 64'(v0));
    chk("abort_drained", 64'(pend.size()), 0);
    chk("abort_done_cycle", 64'(dcyc), 64'(last_rsp_edge + 1));
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    lat_min = 1; lat_max = 1;
    w0 = nwrites;
    send(32'hC000, 32'hD000, 16'd3, t);
    wait_done(1'b0, dcyc);
    post_chk(3, w0, dcyc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
